if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the MIPS32 pipeline; the producer side of the IF/ID pipeline register.
- Owns the PC register and drives if_pc / if_pc_plus_4 into IF/ID.
- Fetches instructions over a request/grant/response instruction-memory handshake.
- Honours the stall vector (stall[0] freezes PC) and accepts branch/exception redirects. Raises a stall request while no instruction is available.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/if_fetch_unit_if.sv | 14 +
 rtl/if_redirect_latch.sv | 65 ++++++
 rtl/if_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 front end: IF state encoding, reset/exception
// vectors and the stall-vector bit owned by the fetch stage.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_VALID = 2'd3
    } if_state_e;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_3180;
    localparam int          STALL_IF       = 0;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant/response channel between the fetch stage
// (master) and the instruction memory (slave).
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_gnt, input imem_rvalid, input imem_rdata);
    modport slave  (input  imem_req, input imem_addr,
                    output imem_gnt, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/if_redirect_latch.sv
// Holds a redirect that cannot be applied yet (pending PC + kill of an in-flight
// fetch) and substitutes the exception vector for misaligned targets.
module if_redirect_latch
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        capture,
    input  logic        arm_kill,
    input  logic        clear,
    output logic [31:0] target,
    output logic [31:0] pending_pc,
    output logic        pending_valid,
    output logic        kill,
    output logic        misalign_exc
);

    logic [31:0] pending_pc_q, pending_pc_d;
    logic        pending_valid_q, pending_valid_d;
    logic        kill_q, kill_d;
    logic        misalign_q, misalign_d;

    always_comb begin
        target          = is_misaligned(redirect_pc) ? EXC_VECTOR : redirect_pc;
        pending_pc_d    = pending_pc_q;
        pending_valid_d = pending_valid_q;
        kill_d          = kill_q;
        misalign_d      = redirect_valid && is_misaligned(redirect_pc);
        // Consuming the pending target wins; a newer capture simply overwrites an older one.
        if (clear) begin
            pending_valid_d = 1'b0;
            kill_d          = 1'b0;
        end else if (capture) begin
            pending_pc_d    = target;
            pending_valid_d = 1'b1;
            if (arm_kill) begin
                kill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_pc_q    <= '0;
            pending_valid_q <= 1'b0;
            kill_q          <= 1'b0;
            misalign_q      <= 1'b0;
        end else begin
            pending_pc_q    <= pending_pc_d;
            pending_valid_q <= pending_valid_d;
            kill_q          <= kill_d;
            misalign_q      <= misalign_d;
        end
    end

    assign pending_pc    = pending_pc_q;
    assign pending_valid = pending_valid_q;
    assign kill          = kill_q;
    assign misalign_exc  = misalign_q;

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS32 instruction-fetch stage: owns the PC, runs one fetch at a time over the
// imem handshake and presents the result to the IF/ID register.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             stall,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            if_pc,
    output logic [31:0]            if_pc_plus_4,
    output logic [31:0]            if_inst,
    output logic                   if_valid,
    output logic                   stallreq_if,
    output logic                   misalign_exc
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc_plus_4_q, if_pc_plus_4_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;

    logic        lat_capture, lat_arm_kill, lat_clear;
    logic [31:0] redir_target, pending_pc;
    logic        pending_valid, kill;

    logic        unused_stall;
    assign unused_stall = ^stall[3:1];

    if_redirect_latch #(.EXC_VECTOR(EXC_VECTOR)) u_redirect (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .capture        (lat_capture),
        .arm_kill       (lat_arm_kill),
        .clear          (lat_clear),
        .target         (redir_target),
        .pending_pc     (pending_pc),
        .pending_valid  (pending_valid),
        .kill           (kill),
        .misalign_exc   (misalign_exc)
    );

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        if_pc_d        = if_pc_q;
        if_pc_plus_4_d = if_pc_plus_4_q;
        if_inst_d      = if_inst_q;
        if_valid_d     = if_valid_q;
        lat_capture    = 1'b0;
        lat_arm_kill   = 1'b0;
        lat_clear      = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                if (redirect_valid) begin
                    pc_d = redir_target;
                end
            end
            ST_FETCH: begin
                if (imem.imem_gnt) begin
                    state_d = ST_WAIT;
                    // Granted in the same cycle as a redirect: let it complete, then drop it.
                    if (redirect_valid) begin
                        lat_capture  = 1'b1;
                        lat_arm_kill = 1'b1;
                    end
                end else if (redirect_valid) begin
                    pc_d = redir_target;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rvalid) begin
                    lat_clear = 1'b1;
                    state_d   = ST_FETCH;
                    if (redirect_valid) begin
                        pc_d = redir_target;
                    end else if (kill) begin
                        pc_d = pending_pc;
                    end else begin
                        if_inst_d      = imem.imem_rdata;
                        if_pc_d        = pc_q;
                        if_pc_plus_4_d = pc_q + 32'd4;
                        if_valid_d     = 1'b1;
                        state_d        = ST_VALID;
                    end
                end else if (redirect_valid) begin
                    lat_capture  = 1'b1;
                    lat_arm_kill = 1'b1;
                end
            end
            ST_VALID: begin
                if (stall[STALL_IF]) begin
                    lat_capture = redirect_valid;
                end else begin
                    lat_clear  = 1'b1;
                    if_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                    if (redirect_valid) begin
                        pc_d = redir_target;
                    end else if (pending_valid) begin
                        pc_d = pending_pc;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_BOOT;
            pc_q           <= RESET_PC;
            if_pc_q        <= RESET_PC;
            if_pc_plus_4_q <= RESET_PC + 32'd4;
            if_inst_q      <= '0;
            if_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            if_pc_q        <= if_pc_d;
            if_pc_plus_4_q <= if_pc_plus_4_d;
            if_inst_q      <= if_inst_d;
            if_valid_q     <= if_valid_d;
        end
    end

    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;
    assign if_pc          = if_pc_q;
    assign if_pc_plus_4   = if_pc_plus_4_q;
    assign if_inst        = if_inst_q;
    assign if_valid       = if_valid_q;
    assign stallreq_if    = (state_q != ST_BOOT) && !if_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a transaction-level model tracks the next
// fetch address, the in-flight fetch and the presented instruction.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_3180;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  stall = 4'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] if_pc, if_pc_plus_4, if_inst;
    logic        if_valid, stallreq_if, misalign_exc;

    if_fetch_unit_if imem ();

    if_fetch_unit #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .if_pc          (if_pc),
        .if_pc_plus_4   (if_pc_plus_4),
        .if_inst        (if_inst),
        .if_valid       (if_valid),
        .stallreq_if    (stallreq_if),
        .misalign_exc   (misalign_exc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h2408_0001;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Model of what the DUT should be doing in the current cycle
    logic        m_boot, m_out, m_kill, m_pres, m_mis;
    logic [31:0] m_out_addr, m_if_pc, m_if_inst, m_exp_pc;
    int          m_cd;

    // Stimulus knobs
    int          k_gnt = 100, k_lat_min = 0, k_lat_max = 0, k_redir = 0, k_stall = 0;
    int          force_mode = 0;
    logic [31:0] force_rp = 32'd0;

    task automatic model_reset();
        m_boot   = 1'b1;
        m_out    = 1'b0;
        m_kill   = 1'b0;
        m_pres   = 1'b0;
        m_mis    = 1'b0;
        m_exp_pc = RST_PC;
        m_cd     = 0;
    endtask

    task automatic check_reset_vals();
        check_eq("rst_imem_req", imem.imem_req, 1'b0);
        check_eq("rst_if_valid", if_valid, 1'b0);
        check_eq("rst_if_pc", if_pc, RST_PC);
        check_eq("rst_if_pc_plus_4", if_pc_plus_4, RST_PC + 32'd4);
        check_eq("rst_if_inst", if_inst, 32'd0);
        check_eq("rst_misalign", misalign_exc, 1'b0);
        check_eq("rst_stallreq", stallreq_if, 1'b0);
    endtask

    task automatic cycle();
        logic        exp_req, do_gnt, do_rv, redir;
        logic [31:0] rp, tgt;
        logic [3:0]  st;
        @(negedge clk);
        exp_req = !m_boot && !m_out && !m_pres;
        check_eq("imem_req", imem.imem_req, exp_req);
        if (exp_req) check_eq("imem_addr", imem.imem_addr, m_exp_pc);
        check_eq("if_valid", if_valid, m_pres);
        check_eq("stallreq_if", stallreq_if, !m_boot && !m_pres);
        check_eq("misalign_exc", misalign_exc, m_mis);
        if (m_pres) begin
            check_eq("if_pc", if_pc, m_if_pc);
            check_eq("if_pc_plus_4", if_pc_plus_4, m_if_pc + 32'd4);
            check_eq("if_inst", if_inst, m_if_inst);
        end

        do_gnt = exp_req && ($urandom_range(0, 99) < k_gnt);
        do_rv  = m_out && (m_cd == 0);
        redir  = $urandom_range(0, 99) < k_redir;
        rp     = $urandom;
        if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
        if (force_mode == 1 || (force_mode == 2 && m_out && !do_rv)) begin
            redir      = 1'b1;
            rp         = force_rp;
            force_mode = 0;
        end
        st    = 4'($urandom);
        st[0] = $urandom_range(0, 99) < k_stall;

        stall            = st;
        redirect_valid   = redir;
        redirect_pc      = rp;
        imem.imem_gnt    = do_gnt;
        imem.imem_rvalid = do_rv || m_boot;
        imem.imem_rdata  = do_rv ? mem_word(m_out_addr) : $urandom;

        tgt   = (rp[1:0] != 2'b00) ? EXC_PC : rp;
        m_mis = redir && (rp[1:0] != 2'b00);
        if (m_boot) begin
            m_boot = 1'b0;
            if (redir) m_exp_pc = tgt;
        end else if (exp_req) begin
            if (do_gnt) begin
                m_out      = 1'b1;
                m_out_addr = m_exp_pc;
                m_kill     = redir;
                m_cd       = $urandom_range(k_lat_min, k_lat_max);
            end
            if (redir) m_exp_pc = tgt;
        end else if (m_out) begin
            if (do_rv) begin
                m_out = 1'b0;
                if (redir) begin
                    m_exp_pc = tgt;
                    $display("[TB] fetch %h dropped (redirect with response)", m_out_addr);
                end else if (m_kill) begin
                    $display("[TB] fetch %h dropped (killed)", m_out_addr);
                end else begin
                    m_pres    = 1'b1;
                    m_if_pc   = m_out_addr;
                    m_if_inst = mem_word(m_out_addr);
                    m_exp_pc  = m_out_addr + 32'd4;
                    $display("[TB] fetch %h inst %h", m_out_addr, m_if_inst);
                end
            end else begin
                m_cd--;
                if (redir) begin
                    m_kill   = 1'b1;
                    m_exp_pc = tgt;
                end
            end
        end else if (m_pres) begin
            if (redir) m_exp_pc = tgt;
            if (!st[0]) m_pres = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_forced(input int mode, input logic [31:0] rp, input string tag);
        int guard;
        force_mode = mode;
        force_rp   = rp;
        guard      = 0;
        while (force_mode != 0 && guard < 40) begin
            cycle();
            guard++;
        end
        check_eq(tag, 32'(force_mode), 32'd0);
        force_mode = 0;
    endtask

    initial begin
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'd0;
        rst = 1'b1;
        #12;
        check_reset_vals();
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Immediate grant, one-cycle response
        run(8);
        // Hold in VALID under stall[0], then release
        k_stall = 100;
        run(10);
        k_stall = 0;
        run(6);
        // Redirect while a fetch is outstanding
        k_lat_min = 1;
        k_lat_max = 2;
        run_forced(2, 32'h0000_4000, "redirect_wait_issued");
        run(8);
        // Misaligned redirect goes to the exception vector
        k_lat_min = 0;
        k_lat_max = 0;
        run_forced(1, 32'h0000_4002, "redirect_misaligned_issued");
        run(8);
        // PC wrap at the top of the address space
        run_forced(1, 32'hFFFF_FFFC, "redirect_wrap_issued");
        run(10);

        // Asynchronous reset while WAIT is outstanding, response arrives during reset
        k_lat_min = 3;
        k_lat_max = 3;
        begin
            int guard = 0;
            while (!m_out && guard < 20) begin
                cycle();
                guard++;
            end
            check_eq("reach_wait", m_out, 1'b1);
        end
        @(posedge clk);
        #2;
        imem.imem_gnt  = 1'b0;
        redirect_valid = 1'b0;
        rst            = 1'b1;
        #1;
        check_reset_vals();
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        model_reset();
        k_lat_min = 0;
        k_lat_max = 0;
        run(8);

        // Random traffic
        k_gnt     = 60;
        k_lat_max = 3;
        k_redir   = 8;
        k_stall   = 30;
        run(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
